k_wta_inhibition: RTL

Clocked, parametrised k-winner-take-all lateral inhibition unit for one STDP column layer. It sits between the neuron array's spike outputs and the STDP update logic. Within one gamma window it latches up to K winning neurons with their spike times, drives a global inhibit once K winners exist, and at window close streams the ordered winner list to the learning block over a valid/ready handshake. It generalises the single-winner combinational inhibition stage: K winners, selectable tie-break order, explicit window control and back-pressured output.

---
 rtl/k_wta_inhibition.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/k_wta_inhibition.sv
// k-winner-take-all lateral inhibition for one STDP column layer: latches up to K
// winners per gamma window, raises a global inhibit, then streams the ordered winner list.
module k_wta_inhibition #(
  parameter int NUM_NEURONS = 16,
  parameter int LOG_NEURONS = 4,
  parameter int TIME_W      = 4,
  parameter int K           = 1,
  parameter int TIE_HIGH    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gamma_start,
  input  logic                   window_end,
  input  logic                   spike_valid,
  input  logic [NUM_NEURONS-1:0] spike_volley,
  input  logic [TIME_W-1:0]      time_val,
  output logic                   inhibit,
  output logic [NUM_NEURONS-1:0] winner_mask,
  output logic [LOG_NEURONS:0]   winner_count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LOG_NEURONS:0]   out_id,
  output logic [TIME_W-1:0]      out_time,
  output logic                   out_last
);

  localparam int ID_W = LOG_NEURONS + 1;
  localparam logic [ID_W-1:0] NO_WINNER = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t                 state_r;
  logic [ID_W-1:0]        id_list_r   [K];
  logic [TIME_W-1:0]      time_list_r [K];
  logic [ID_W-1:0]        rd_idx_r;

  logic [ID_W-1:0]        nxt_id_s    [K];
  logic [TIME_W-1:0]      nxt_time_s  [K];
  logic [NUM_NEURONS-1:0] nxt_mask_s;
  logic [NUM_NEURONS-1:0] cand_s;
  logic [ID_W-1:0]        nxt_count_s;
  logic                   take_s;
  int                     cnt_s;

  // Position p in the scan order maps to a neuron index according to the tie-break rule.
  function automatic int pri_idx(input int p);
    return (TIE_HIGH != 0) ? (NUM_NEURONS - 1 - p) : p;
  endfunction

  // Accept candidates of the current volley in priority order until K slots are filled.
  always_comb begin
    nxt_id_s   = id_list_r;
    nxt_time_s = time_list_r;
    nxt_mask_s = winner_mask;
    cand_s     = spike_volley & ~winner_mask;
    cnt_s      = int'(winner_count);
    take_s     = (state_r == COLLECT) && spike_valid && !gamma_start;
    for (int p = 0; p < NUM_NEURONS; p++) begin
      if (take_s && cand_s[pri_idx(p)] && (cnt_s < K)) begin
        for (int s = 0; s < K; s++) begin
          if (s == cnt_s) begin
            nxt_id_s[s]   = ID_W'(pri_idx(p));
            nxt_time_s[s] = time_val;
          end else begin
            nxt_id_s[s]   = nxt_id_s[s];
          end
        end
        nxt_mask_s[pri_idx(p)] = 1'b1;
        cnt_s = cnt_s + 1;
      end else begin
        cnt_s = cnt_s;
      end
    end
    nxt_count_s = ID_W'(cnt_s);
  end

  // Window FSM, winner list storage and the registered report stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      inhibit      <= 1'b0;
      winner_mask  <= '0;
      winner_count <= '0;
      out_valid    <= 1'b0;
      out_id       <= '0;
      out_time     <= '0;
      out_last     <= 1'b0;
      rd_idx_r     <= '0;
      for (int s = 0; s < K; s++) begin
        id_list_r[s]   <= '0;
        time_list_r[s] <= '0;
      end
    end else if (gamma_start) begin
      state_r      <= COLLECT;
      inhibit      <= 1'b0;
      winner_mask  <= '0;
      winner_count <= '0;
      out_valid    <= 1'b0;
      out_id       <= '0;
      out_time     <= '0;
      out_last     <= 1'b0;
      rd_idx_r     <= '0;
      for (int s = 0; s < K; s++) begin
        id_list_r[s]   <= '0;
        time_list_r[s] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        COLLECT: begin
          id_list_r    <= nxt_id_s;
          time_list_r  <= nxt_time_s;
          winner_mask  <= nxt_mask_s;
          winner_count <= nxt_count_s;
          if (nxt_count_s == ID_W'(K)) begin
            inhibit <= 1'b1;
          end
          // Close on the registered count, but a volley arriving with window_end still lands.
          if ((winner_count == ID_W'(K)) || window_end) begin
            state_r   <= REPORT;
            out_valid <= 1'b1;
            rd_idx_r  <= '0;
            if (nxt_count_s == '0) begin
              out_id   <= NO_WINNER;
              out_time <= '0;
              out_last <= 1'b1;
            end else begin
              out_id   <= nxt_id_s[0];
              out_time <= nxt_time_s[0];
              out_last <= (nxt_count_s == ID_W'(1));
            end
          end
        end
        REPORT: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              state_r   <= IDLE;
            end else begin
              rd_idx_r <= rd_idx_r + ID_W'(1);
              out_last <= ((rd_idx_r + ID_W'(2)) == winner_count);
              for (int s = 1; s < K; s++) begin
                if (s == int'(rd_idx_r) + 1) begin
                  out_id   <= id_list_r[s];
                  out_time <= time_list_r[s];
                end
              end
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
